// File: rtl/isp_pkg.sv
// Shared ISP definitions: nominal frame geometry and the border-padding FSM states.
package isp_pkg;

   localparam int unsigned ISP_WIDTH  = 320;
   localparam int unsigned ISP_HEIGHT = 240;

   typedef enum logic [2:0] {
      IDLE,
      TOP,
      LEFT,
      PIX,
      RIGHT,
      BOTTOM
   } pad_state_t;

endpackage

// File: rtl/pad_fifo.sv
// Single-clock show-ahead FIFO. rd_data always shows the oldest word; a write
// is visible to the reader one cycle later. A write while full is accepted when
// a read happens in the same cycle.
module pad_fifo #(
   parameter int unsigned DEPTH  = 512,
   parameter int unsigned DATA_W = 32,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       usedw
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              do_wr;
   logic              do_rd;

   // Occupancy, status flags and the accepted read/write strobes.
   always_comb begin
      usedw   = wr_ptr - rd_ptr;
      full    = (usedw == FULL_LVL);
      empty   = (usedw == '0);
      do_rd   = rd_en && !empty;
      do_wr   = wr_en && (!full || do_rd);
      rd_data = mem[rd_ptr[AW-1:0]];
   end

   // Pointer update; flush discards every stored word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage array, no reset needed since pointers define validity.
   always_ff @(posedge clk) begin
      if (do_wr && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/pad_inserter.sv
// Border-padding stage: wraps a WIDTH x HEIGHT pixel stream in a one-pixel zero
// border, emitting (WIDTH+2) x (HEIGHT+2) words towards the bus write FIFO.
module pad_inserter
   import isp_pkg::*;
#(
   parameter int unsigned WIDTH  = ISP_WIDTH,
   parameter int unsigned HEIGHT = ISP_HEIGHT,
   parameter int unsigned DEPTH  = 512
) (
   input  logic        GPIO1_PIXLCLK,
   input  logic        reset_n,
   input  logic        iFrameStart,
   input  logic [31:0] iData,
   input  logic        sCCD_DVAL,
   input  logic        iReady,
   output logic [31:0] oData,
   output logic        oValid,
   output logic        oBusy,
   output logic        oFrameDone,
   output logic        oOverflow
);

   localparam int unsigned CW   = $clog2(WIDTH + 2);
   localparam int unsigned RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int unsigned NPIX = WIDTH * HEIGHT;
   localparam int unsigned PW   = $clog2(NPIX + 1);
   localparam int unsigned AW   = $clog2(DEPTH);

   localparam logic [CW-1:0] COL_EDGE_LAST = CW'(WIDTH + 1);
   localparam logic [CW-1:0] COL_PIX_LAST  = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST      = RW'(HEIGHT - 1);
   localparam logic [PW-1:0] PIX_TOTAL     = PW'(NPIX);

   pad_state_t    state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [PW-1:0] pix_cnt;

   logic [31:0]   fifo_q;
   logic          fifo_full;
   logic          fifo_empty;
   logic [AW:0]   fifo_usedw_unused;

   logic          can_issue;
   logic          pop;
   logic          push_req;
   logic          drop;

   pad_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (32)
   ) u_fifo (
      .clk     (GPIO1_PIXLCLK),
      .rst_n   (reset_n),
      .flush   (iFrameStart),
      .wr_en   (push_req),
      .wr_data (iData),
      .rd_en   (pop),
      .rd_data (fifo_q),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .usedw   (fifo_usedw_unused)
   );

   // Issue/pop/push decisions; a frame start pre-empts everything this cycle.
   always_comb begin
      can_issue = 1'b0;
      pop       = 1'b0;
      push_req  = 1'b0;
      drop      = 1'b0;
      if (!iFrameStart && (state != IDLE) && iReady) begin
         can_issue = (state != PIX) || !fifo_empty;
      end
      pop      = can_issue && (state == PIX);
      push_req = sCCD_DVAL && oBusy && !iFrameStart && (pix_cnt < PIX_TOTAL);
      drop     = push_req && fifo_full && !pop;
   end

   // Output FSM with registered data/valid/status outputs and input pixel count.
   always_ff @(posedge GPIO1_PIXLCLK or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         pix_cnt    <= '0;
         oData      <= '0;
         oValid     <= 1'b0;
         oBusy      <= 1'b0;
         oFrameDone <= 1'b0;
         oOverflow  <= 1'b0;
      end else begin
         oValid     <= 1'b0;
         oData      <= '0;
         oFrameDone <= 1'b0;

         if (push_req) pix_cnt   <= pix_cnt + 1'b1;
         if (drop)     oOverflow <= 1'b1;

         if (iFrameStart) begin
            state     <= TOP;
            col       <= '0;
            row       <= '0;
            pix_cnt   <= '0;
            oOverflow <= 1'b0;
            oBusy     <= 1'b1;
         end else if (can_issue) begin
            oValid <= 1'b1;
            if (state == PIX) oData <= fifo_q;
            case (state)
               TOP: begin
                  if (col == COL_EDGE_LAST) begin
                     col   <= '0;
                     state <= LEFT;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
               LEFT: begin
                  col   <= '0;
                  state <= PIX;
               end
               PIX: begin
                  if (col == COL_PIX_LAST) begin
                     col   <= '0;
                     state <= RIGHT;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
               RIGHT: begin
                  col <= '0;
                  if (row == ROW_LAST) begin
                     row   <= '0;
                     state <= BOTTOM;
                  end else begin
                     row   <= row + 1'b1;
                     state <= LEFT;
                  end
               end
               BOTTOM: begin
                  if (col == COL_EDGE_LAST) begin
                     col        <= '0;
                     state      <= IDLE;
                     oBusy      <= 1'b0;
                     oFrameDone <= 1'b1;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pad_inserter.sv
// Bench for pad_inserter: three instances share stimulus, each test checks one.
// Instance 0: 4x2, depth 8. Instance 1: 16x4, depth 8. Instance 2: 16x5, depth 64.
module tb_pad_inserter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        iFrameStart;
   logic [31:0] iData;
   logic        sCCD_DVAL;
   logic        iReady;

   logic        ov   [3];
   logic [31:0] od   [3];
   logic        ob   [3];
   logic        odn  [3];
   logic        oovf [3];

   always #5 clk = ~clk;

   pad_inserter #(.WIDTH(4), .HEIGHT(2), .DEPTH(8)) u_a (
      .GPIO1_PIXLCLK(clk), .reset_n(reset_n), .iFrameStart(iFrameStart),
      .iData(iData), .sCCD_DVAL(sCCD_DVAL), .iReady(iReady),
      .oData(od[0]), .oValid(ov[0]), .oBusy(ob[0]), .oFrameDone(odn[0]), .oOverflow(oovf[0]));

   pad_inserter #(.WIDTH(16), .HEIGHT(4), .DEPTH(8)) u_b (
      .GPIO1_PIXLCLK(clk), .reset_n(reset_n), .iFrameStart(iFrameStart),
      .iData(iData), .sCCD_DVAL(sCCD_DVAL), .iReady(iReady),
      .oData(od[1]), .oValid(ov[1]), .oBusy(ob[1]), .oFrameDone(odn[1]), .oOverflow(oovf[1]));

   pad_inserter #(.WIDTH(16), .HEIGHT(5), .DEPTH(64)) u_c (
      .GPIO1_PIXLCLK(clk), .reset_n(reset_n), .iFrameStart(iFrameStart),
      .iData(iData), .sCCD_DVAL(sCCD_DVAL), .iReady(iReady),
      .oData(od[2]), .oValid(ov[2]), .oBusy(ob[2]), .oFrameDone(odn[2]), .oOverflow(oovf[2]));

   int          total = 0;
   int          bad   = 0;
   bit          rnd_ready = 1'b0;
   logic [31:0] outq [3][$];
   int          done_cnt [3];
   logic [31:0] pixq [$];

   typedef struct {
      bit          fs;
      bit          dval;
      logic [31:0] data;
      bit          rdy;
      bit          v;
      logic [31:0] d;
      bit          busy;
      bit          done;
   } vec_t;

   vec_t tbl [28];

   // Output collectors: every valid word and every done pulse, per instance.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (ov[k] === 1'b1) outq[k].push_back(od[k]);
         if (odn[k] === 1'b1) done_cnt[k]++;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ready) iReady = 1'($urandom_range(0, 1));
   endtask

   task automatic start_frame(input int sel);
      sCCD_DVAL   = 1'b0;
      iFrameStart = 1'b1;
      tick();
      iFrameStart = 1'b0;
      outq[sel].delete();
      done_cnt[sel] = 0;
   endtask

   // Feeds one frame of random pixels after start_frame, then checks the
   // collected output against the padded image computed from pixq.
   task automatic feed_and_check(input int sel, input int w, input int h,
                                 input int blank, input string tag);
      int          n;
      int          exp_n;
      int          r;
      int          c;
      logic [31:0] e;
      logic [31:0] got;
      pixq.delete();
      for (int rr = 0; rr < h; rr++) begin
         for (int cc = 0; cc < w; cc++) begin
            iData     = $urandom;
            pixq.push_back(iData);
            sCCD_DVAL = 1'b1;
            tick();
         end
         sCCD_DVAL = 1'b0;
         repeat (blank) tick();
      end
      for (int i = 0; i < 5; i++) begin
         iData     = $urandom;
         sCCD_DVAL = 1'b1;
         tick();
      end
      sCCD_DVAL = 1'b0;
      n = 0;
      while (done_cnt[sel] == 0 && n < 20000) begin
         tick();
         n++;
      end
      chk($sformatf("%s frame done seen", tag), 32'(done_cnt[sel] != 0), 32'd1);
      repeat (5) tick();
      exp_n = (w + 2) * (h + 2);
      chk($sformatf("%s word count", tag), 32'(outq[sel].size()), 32'(exp_n));
      for (int i = 0; i < exp_n; i++) begin
         r = i / (w + 2);
         c = i % (w + 2);
         if (r == 0 || r == h + 1 || c == 0 || c == w + 1) e = '0;
         else e = pixq[(r - 1) * w + (c - 1)];
         got = (i < outq[sel].size()) ? outq[sel][i] : 'x;
         chk($sformatf("%s word %0d", tag, i), got, e);
      end
      chk($sformatf("%s done pulses", tag), 32'(done_cnt[sel]), 32'd1);
      chk($sformatf("%s overflow", tag), 32'(oovf[sel]), 32'd0);
      chk($sformatf("%s busy after done", tag), 32'(ob[sel]), 32'd0);
      n = outq[sel].size();
      for (int i = 0; i < 20; i++) begin
         iData     = $urandom;
         sCCD_DVAL = 1'b1;
         tick();
      end
      sCCD_DVAL = 1'b0;
      repeat (5) tick();
      chk($sformatf("%s idle pushes ignored", tag), 32'(outq[sel].size()), 32'(n));
      chk($sformatf("%s idle busy", tag), 32'(ob[sel]), 32'd0);
   endtask

   task automatic set_vec(input int i, input bit fs, input bit dval, input int data,
                          input bit rdy, input bit v, input int d, input bit busy,
                          input bit done);
      tbl[i] = '{fs, dval, 32'(data), rdy, v, 32'(d), busy, done};
   endtask

   initial begin
      int n;
      //          i   fs dv data rdy | v  d  busy done
      set_vec( 0, 1, 0,  0, 1,   0, 0, 1, 0);
      set_vec( 1, 0, 1,  1, 1,   1, 0, 1, 0);
      set_vec( 2, 0, 1,  2, 1,   1, 0, 1, 0);
      set_vec( 3, 0, 1,  3, 1,   1, 0, 1, 0);
      set_vec( 4, 0, 1,  4, 1,   1, 0, 1, 0);
      set_vec( 5, 0, 1,  5, 1,   1, 0, 1, 0);
      set_vec( 6, 0, 1,  6, 1,   1, 0, 1, 0);
      set_vec( 7, 0, 1,  7, 1,   1, 0, 1, 0);
      set_vec( 8, 0, 1,  8, 1,   1, 1, 1, 0);
      set_vec( 9, 0, 0,  0, 0,   0, 0, 1, 0);
      set_vec(10, 0, 1, 99, 1,   1, 2, 1, 0);
      set_vec(11, 0, 0,  0, 1,   1, 3, 1, 0);
      set_vec(12, 0, 0,  0, 1,   1, 4, 1, 0);
      set_vec(13, 0, 0,  0, 1,   1, 0, 1, 0);
      set_vec(14, 0, 0,  0, 1,   1, 0, 1, 0);
      set_vec(15, 0, 0,  0, 0,   0, 0, 1, 0);
      set_vec(16, 0, 0,  0, 1,   1, 5, 1, 0);
      set_vec(17, 0, 0,  0, 1,   1, 6, 1, 0);
      set_vec(18, 0, 0,  0, 1,   1, 7, 1, 0);
      set_vec(19, 0, 0,  0, 1,   1, 8, 1, 0);
      set_vec(20, 0, 0,  0, 1,   1, 0, 1, 0);
      set_vec(21, 0, 0,  0, 1,   1, 0, 1, 0);
      set_vec(22, 0, 0,  0, 1,   1, 0, 1, 0);
      set_vec(23, 0, 0,  0, 1,   1, 0, 1, 0);
      set_vec(24, 0, 0,  0, 1,   1, 0, 1, 0);
      set_vec(25, 0, 0,  0, 1,   1, 0, 1, 0);
      set_vec(26, 0, 0,  0, 1,   1, 0, 0, 1);
      set_vec(27, 0, 0,  0, 1,   0, 0, 0, 0);

      reset_n     = 1'b0;
      iFrameStart = 1'b0;
      iData       = '0;
      sCCD_DVAL   = 1'b0;
      iReady      = 1'b1;
      repeat (3) tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset oValid[%0d]", k), 32'(ov[k]), 32'd0);
         chk($sformatf("reset oData[%0d]", k), od[k], 32'd0);
         chk($sformatf("reset oBusy[%0d]", k), 32'(ob[k]), 32'd0);
         chk($sformatf("reset oFrameDone[%0d]", k), 32'(odn[k]), 32'd0);
         chk($sformatf("reset oOverflow[%0d]", k), 32'(oovf[k]), 32'd0);
      end
      reset_n = 1'b1;
      tick();

      // Cycle-exact 4x2 frame with stalls and an excess pixel.
      for (int i = 0; i < 28; i++) begin
         iFrameStart = tbl[i].fs;
         sCCD_DVAL   = tbl[i].dval;
         iData       = tbl[i].data;
         iReady      = tbl[i].rdy;
         tick();
         chk($sformatf("tbl[%0d] oValid", i), 32'(ov[0]), 32'(tbl[i].v));
         if (tbl[i].v) chk($sformatf("tbl[%0d] oData", i), od[0], tbl[i].d);
         chk($sformatf("tbl[%0d] oBusy", i), 32'(ob[0]), 32'(tbl[i].busy));
         chk($sformatf("tbl[%0d] oFrameDone", i), 32'(odn[0]), 32'(tbl[i].done));
         chk($sformatf("tbl[%0d] oOverflow", i), 32'(oovf[0]), 32'd0);
      end
      iFrameStart = 1'b0;
      sCCD_DVAL   = 1'b0;
      iReady      = 1'b1;

      // Overflow: 16 pushes into an 8-deep FIFO with the output blocked.
      iReady = 1'b0;
      start_frame(1);
      for (int i = 1; i <= 16; i++) begin
         sCCD_DVAL = 1'b1;
         iData     = 32'(100 + i);
         tick();
         if (i == 8) chk("ovf after 8th push", 32'(oovf[1]), 32'd0);
         if (i == 9) chk("ovf after 9th push", 32'(oovf[1]), 32'd1);
      end
      sCCD_DVAL = 1'b0;
      repeat (4) tick();
      chk("ovf no output while blocked", 32'(outq[1].size()), 32'd0);
      iReady = 1'b1;
      repeat (60) tick();
      chk("ovf word count", 32'(outq[1].size()), 32'd27);
      for (int j = 0; j < 19; j++)
         chk($sformatf("ovf border word %0d", j),
             (j < outq[1].size()) ? outq[1][j] : 32'hxxxxxxxx, 32'd0);
      for (int j = 0; j < 8; j++)
         chk($sformatf("ovf pixel %0d", j),
             (19 + j < outq[1].size()) ? outq[1][19 + j] : 32'hxxxxxxxx, 32'(101 + j));
      chk("ovf sticky", 32'(oovf[1]), 32'd1);
      chk("ovf no done", 32'(done_cnt[1]), 32'd0);
      start_frame(1);
      chk("ovf cleared by frame start", 32'(oovf[1]), 32'd0);
      chk("ovf busy after restart", 32'(ob[1]), 32'd1);

      // Abort mid-PIX: FIFO contents must be discarded.
      iReady = 1'b1;
      start_frame(0);
      for (int i = 1; i <= 8; i++) begin
         sCCD_DVAL = 1'b1;
         iData     = 32'(i);
         tick();
      end
      sCCD_DVAL = 1'b0;
      n = 0;
      while (outq[0].size() < 10 && n < 50) begin
         tick();
         n++;
      end
      chk("abort reached PIX", 32'(outq[0].size() >= 10), 32'd1);
      start_frame(0);
      chk("abort oValid", 32'(ov[0]), 32'd0);
      chk("abort oBusy", 32'(ob[0]), 32'd1);
      feed_and_check(0, 4, 2, 4, "abort");

      // Asynchronous reset mid-PIX.
      start_frame(0);
      for (int i = 1; i <= 8; i++) begin
         sCCD_DVAL = 1'b1;
         iData     = 32'(i);
         tick();
      end
      sCCD_DVAL = 1'b0;
      n = 0;
      while (outq[0].size() < 10 && n < 50) begin
         tick();
         n++;
      end
      reset_n = 1'b0;
      #1;
      chk("rst oValid", 32'(ov[0]), 32'd0);
      chk("rst oData", od[0], 32'd0);
      chk("rst oBusy", 32'(ob[0]), 32'd0);
      chk("rst oFrameDone", 32'(odn[0]), 32'd0);
      chk("rst oOverflow", 32'(oovf[0]), 32'd0);
      repeat (3) tick();
      chk("rst held oValid", 32'(ov[0]), 32'd0);
      reset_n = 1'b1;
      repeat (3) tick();
      chk("rst stays idle", 32'(ob[0]), 32'd0);
      start_frame(0);
      feed_and_check(0, 4, 2, 4, "after reset");

      // Random backpressure against the padded-image model.
      rnd_ready = 1'b1;
      for (int f = 0; f < 3; f++) begin
         start_frame(2);
         feed_and_check(2, 16, 5, 30, $sformatf("rand16x5 f%0d", f));
      end
      start_frame(0);
      feed_and_check(0, 4, 2, 4, "rand4x2");
      rnd_ready = 1'b0;
      iReady    = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
